// File: rtl/din_pkg.sv
// Shared types and defaults for the DAC DIN serializer.
package din_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} din_state_t;

  // Defaults for the DAC variant: 24-bit frame carrying a 16-bit sample.
  localparam int DIN_DATA_W  = 24;
  localparam int DIN_CLK_DIV = 2;
  localparam int DIN_GAP_CYC = 2;

  // Counter width that never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sclk_tick_gen.sv
// Free-running sclk half-period divider; clr restarts at the top of a high half.
module sclk_tick_gen
  import din_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic fall_tick,
  output logic rise_tick
);

  localparam int DIV_W = cnt_w(CLK_DIV);

  logic [DIV_W-1:0] div_q, div_d;
  logic             high_q, high_d;
  logic             half_end;

  assign half_end  = (div_q == DIV_W'(CLK_DIV - 1));
  assign fall_tick = high_q & half_end;
  assign rise_tick = ~high_q & half_end;

  always_comb begin
    div_d  = half_end ? '0 : div_q + DIV_W'(1);
    high_d = half_end ? ~high_q : high_q;
    if (clr) begin
      div_d  = '0;
      high_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      high_q <= 1'b1;
    end else begin
      div_q  <= div_d;
      high_q <= high_d;
    end
  end

endmodule

// File: rtl/din_serializer.sv
// Parallel-to-serial DAC DIN driver with self-generated sclk and sync_n framing.
module din_serializer
  import din_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 2,
  parameter int GAP_CYC   = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              din,
  output logic              sclk,
  output logic              sync_n,
  output logic              busy,
  output logic              done
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYC - 1);

  function automatic logic head_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  din_state_t        state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic sclk_q, sclk_d, sync_n_q, sync_n_d, din_q, din_d;
  logic busy_q, busy_d, done_q, done_d, ready_q, ready_d;
  logic clr, fall_tick, rise_tick;

  sclk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick)
  );

  // Ready is forced low combinationally while reset is held.
  assign word_ready = ready_q & ~rst;
  assign din        = din_q;
  assign sclk       = sclk_q;
  assign sync_n     = sync_n_q;
  assign busy       = busy_q;
  assign done       = done_q;

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    sclk_d   = sclk_q;
    sync_n_d = sync_n_q;
    din_d    = din_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ready_d  = ready_q;
    clr      = 1'b0;
    case (state_q)
      IDLE: begin
        if (word_valid && word_ready) begin
          state_d  = SHIFT;
          sh_d     = word_in;
          bit_d    = '0;
          clr      = 1'b1;
          sclk_d   = 1'b1;
          sync_n_d = 1'b0;
          din_d    = head_bit(word_in);
          busy_d   = 1'b1;
          ready_d  = 1'b0;
        end
      end
      SHIFT: begin
        if (fall_tick) begin
          sclk_d = 1'b0;
        end else if (rise_tick) begin
          sclk_d = 1'b1;
          if (bit_q == LAST_BIT) begin
            state_d  = GAP;
            gap_d    = '0;
            sync_n_d = 1'b1;
            done_d   = 1'b1;
            din_d    = 1'b0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
            sh_d  = shift_word(sh_q);
            din_d = head_bit(sh_d);
          end
        end
      end
      GAP: begin
        if (gap_q == LAST_GAP) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bit_q    <= '0;
      gap_q    <= '0;
      sclk_q   <= 1'b1;
      sync_n_q <= 1'b1;
      din_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      sclk_q   <= sclk_d;
      sync_n_q <= sync_n_d;
      din_q    <= din_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  // Shift register holds data only; it needs no reset.
  always_ff @(posedge clk) begin
    sh_q <= sh_d;
  end

endmodule
